// File: rtl/clk_reset_seq.sv
// clk_reset_seq: multi-channel clock divider, reset stretcher and CPU run/halt/step controller
// Optional feature macro CLKGEN_STEP_EN: when defined, halt/step control with HALT and STEP states;
// when undefined, halt/step are ignored and the controller only moves between RST and RUN.
module clk_reset_seq #(
    parameter int NCH         = 2,
    parameter int CNT_W       = 25,
    parameter int RESET_TICKS = 8
) (
    input  logic                 CLK,
    input  logic                 reset_n,
    input  logic [NCH*CNT_W-1:0] div,
    input  logic                 soft_reset,
    input  logic                 halt,
    input  logic                 step,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick,
    output logic                 sys_reset,
    output logic                 cpu_en,
    output logic [1:0]           state
);
    localparam int RW = $clog2(RESET_TICKS + 1);
    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    typedef enum logic [1:0] {RST = 2'd0, RUN = 2'd1, HALT = 2'd2, STEP = 2'd3} state_t;
    state_t st, st_nxt;
    logic [NCH-1:0] tick_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic cpu_en_nxt;
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] d, shadow, per, cnt;
        logic co_q, tk_q;
        assign d = div[i*CNT_W +: CNT_W];
        assign per = (cnt == '0) ? ((d < MIN_P) ? MIN_P : d) : shadow;
        assign tick_nxt[i] = cnt == per - ONE;
        // count through one period; the divisor is captured only at the start of a period
        always_ff @(posedge CLK or negedge reset_n) begin
            if (!reset_n) begin
                cnt    <= '0;
                shadow <= MIN_P;
                co_q   <= 1'b0;
                tk_q   <= 1'b0;
            end else begin
                cnt  <= tick_nxt[i] ? '0 : cnt + ONE;
                if (cnt == '0) shadow <= per;
                co_q <= cnt < (per >> 1);
                tk_q <= tick_nxt[i];
            end
        end
        assign clk_out[i] = co_q;
        assign tick[i]    = tk_q;
    end
    assign rcnt_nxt = soft_reset ? RW'(RESET_TICKS) : (tick[0] && rcnt != '0) ? rcnt - RW'(1) : rcnt;
    // reset stretcher: hold sys_reset until RESET_TICKS channel-0 ticks have been seen
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            rcnt      <= RW'(RESET_TICKS);
            sys_reset <= 1'b1;
        end else begin
            rcnt      <= rcnt_nxt;
            sys_reset <= rcnt_nxt != '0;
        end
    end
`ifdef CLKGEN_STEP_EN
    // controller next state; a step owes exactly one enable, delivered on the next channel-0 tick
    always_comb begin
        st_nxt = st;
        if (soft_reset) st_nxt = RST;
        else begin
            case (st)
                RST:     if (rcnt_nxt == '0) st_nxt = halt ? HALT : RUN;
                RUN:     if (halt) st_nxt = HALT;
                HALT:    st_nxt = !halt ? RUN : step ? STEP : HALT;
                STEP:    if (tick_nxt[0]) st_nxt = halt ? HALT : RUN;
                default: st_nxt = RST;
            endcase
        end
        cpu_en_nxt = tick_nxt[0] && !soft_reset && (st_nxt == RUN || st == STEP);
    end
`else
    logic unused_ctl;
    assign unused_ctl = halt ^ step;
    // controller next state: run as soon as the reset sequence completes
    always_comb begin
        st_nxt     = soft_reset ? RST : (rcnt_nxt == '0) ? RUN : st;
        cpu_en_nxt = tick_nxt[0] && !soft_reset && st_nxt == RUN;
    end
`endif
    // controller state and cpu enable registers
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            st     <= RST;
            cpu_en <= 1'b0;
        end else begin
            st     <= st_nxt;
            cpu_en <= cpu_en_nxt;
        end
    end
    assign state = st;
endmodule

// File: tb/tb_clk_reset_seq.sv
// tb_clk_reset_seq: self-checking bench for clk_reset_seq against a period/tick-count reference model
module tb_clk_reset_seq;
    localparam int NCH = 2;
    localparam int CNT_W = 25;
    localparam int RT = 8;
    localparam int M_RST = 0, M_RUN = 1, M_HALT = 2, M_STEP = 3;
    localparam logic [2*NCH+3:0] RST_VEC = {{NCH{1'b0}}, {NCH{1'b0}}, 1'b1, 1'b0, 2'b00};
    logic CLK = 1'b0;
    logic reset_n = 1'b0;
    logic soft_reset = 1'b0;
    logic halt = 1'b0;
    logic step = 1'b0;
    logic [NCH*CNT_W-1:0] div = '0;
    logic [NCH-1:0] clk_out, tick;
    logic sys_reset, cpu_en;
    logic [1:0] state;
    int total = 0;
    int bad = 0;
    int cyc;
    int m_start[NCH];
    int m_per[NCH];
    int m_ticks, m_mode;
    logic [NCH-1:0] m_tick, m_clk;
    logic m_sys, m_cpu;

    always #5 CLK = ~CLK;

    clk_reset_seq #(.NCH(NCH), .CNT_W(CNT_W), .RESET_TICKS(RT)) dut (
        .CLK(CLK), .reset_n(reset_n), .div(div), .soft_reset(soft_reset), .halt(halt), .step(step),
        .clk_out(clk_out), .tick(tick), .sys_reset(sys_reset), .cpu_en(cpu_en), .state(state)
    );

    function automatic logic [2*NCH+3:0] obs();
        return {clk_out, tick, sys_reset, cpu_en, state};
    endfunction

    function automatic logic [2*NCH+3:0] expv();
        return {m_clk, m_tick, m_sys, m_cpu, 2'(m_mode)};
    endfunction

    task automatic set_div(input int d0, input int d1);
        div = {CNT_W'(d1), CNT_W'(d0)};
    endtask

    task automatic model_init();
        cyc = 0;
        for (int c = 0; c < NCH; c++) begin
            m_start[c] = 0;
            m_per[c] = 2;
        end
        m_ticks = 0;
        m_mode = M_RST;
        m_tick = '0;
        m_clk = '0;
        m_sys = 1'b1;
        m_cpu = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        reset_n = 1'b1;
        model_init();
    endtask

    // Each period starts in the cycle its previous tick is visible (or cycle 0), takes max(D,2)
    // from the divisor present in that cycle, is high for the first floor(P/2) cycles and ticks P cycles later.
    task automatic advance();
        int n, k, d, nmode;
        logic [NCH-1:0] t, co;
        logic nsys, ncpu;
        n = cyc + 1;
        for (int c = 0; c < NCH; c++) begin
            if (m_start[c] == cyc) begin
                d = int'(div[c*CNT_W +: CNT_W]);
                m_per[c] = d < 2 ? 2 : d;
            end
            k = n - m_start[c];
            t[c] = k == m_per[c];
            co[c] = (k >= 1) && (k - 1 < m_per[c] / 2);
        end
        if (soft_reset) m_ticks = 0;
        else if (m_tick[0] && m_ticks < RT) m_ticks++;
        nsys = m_ticks < RT;
`ifdef CLKGEN_STEP_EN
        if (nsys) nmode = M_RST;
        else begin
            case (m_mode)
                M_RST, M_RUN: nmode = halt ? M_HALT : M_RUN;
                M_HALT:       nmode = !halt ? M_RUN : step ? M_STEP : M_HALT;
                default:      nmode = !t[0] ? M_STEP : halt ? M_HALT : M_RUN;
            endcase
        end
        ncpu = t[0] && !nsys && (nmode == M_RUN || m_mode == M_STEP);
`else
        nmode = nsys ? M_RST : M_RUN;
        ncpu = t[0] && !nsys;
`endif
        for (int c = 0; c < NCH; c++) if (t[c]) m_start[c] = n;
        @(posedge CLK);
        @(negedge CLK);
        cyc = n;
        m_tick = t;
        m_clk = co;
        m_sys = nsys;
        m_mode = nmode;
        m_cpu = ncpu;
    endtask

    task automatic test_reset();
        set_div(5, 3);
        reset_n = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        total++;
        if (obs() !== RST_VEC) begin bad++; $display("FAIL reset_values got=%b exp=%b", obs(), RST_VEC); end
        reset_n = 1'b1;
        model_init();
        repeat (12) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
    endtask

    task automatic test_divider();
        int first0, first1, hi0, hi1;
        first0 = -1; first1 = -1; hi0 = 0; hi1 = 0;
        set_div(120, 7);
        apply_reset();
        repeat (250) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL divider cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            if (tick[0] && first0 < 0) first0 = cyc;
            if (tick[1] && first1 < 0) first1 = cyc;
            if (cyc <= 120 && clk_out[0]) hi0++;
            if (cyc <= 7 && clk_out[1]) hi1++;
        end
        total++;
        if (first0 != 120) begin bad++; $display("FAIL first_tick0 got=%0d exp=120", first0); end
        total++;
        if (first1 != 7) begin bad++; $display("FAIL first_tick1 got=%0d exp=7", first1); end
        total++;
        if (hi0 != 60) begin bad++; $display("FAIL clk0_high got=%0d exp=60", hi0); end
        total++;
        if (hi1 != 3) begin bad++; $display("FAIL clk1_high got=%0d exp=3", hi1); end
    endtask

    task automatic test_small_div();
        int nt;
        for (int d = 0; d < 2; d++) begin
            nt = 0;
            set_div(d, 3);
            apply_reset();
            repeat (10) begin
                advance();
                total++;
                if (obs() !== expv()) begin bad++; $display("FAIL small_div d=%0d cyc=%0d got=%b exp=%b", d, cyc, obs(), expv()); end
                nt += int'(tick[0]);
            end
            total++;
            if (nt != 5) begin bad++; $display("FAIL small_div_ticks d=%0d got=%0d exp=5", d, nt); end
        end
    endtask

    task automatic test_mid_change();
        int tq[$];
        set_div(120, 7);
        apply_reset();
        repeat (30) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL mid_change cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
        set_div(10, 7);
        repeat (115) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL mid_change cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            if (tick[0]) tq.push_back(cyc);
        end
        total++;
        if (tq.size() < 3 || tq[0] != 120 || tq[1] != 130 || tq[2] != 140)
            begin bad++; $display("FAIL mid_change_ticks got=%p exp='{120,130,140}", tq); end
    endtask

    task automatic test_reset_seq();
        int fall, first_en;
        fall = -1; first_en = -1;
        set_div(4, 5);
        apply_reset();
        repeat (40) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL reset_seq cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            if (!sys_reset && fall < 0) fall = cyc;
            if (cpu_en && first_en < 0) first_en = cyc;
        end
        total++;
        if (fall != 33) begin bad++; $display("FAIL sys_reset_fall got=%0d exp=33", fall); end
        total++;
        if (first_en != 36) begin bad++; $display("FAIL first_cpu_en got=%0d exp=36", first_en); end
    endtask

    task automatic test_soft_reset();
        int fall, n_en;
        fall = -1; n_en = 0;
        set_div(4, 5);
        apply_reset();
        repeat (20) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL soft_reset cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
        total++;
        if (tick[0] !== 1'b1) begin bad++; $display("FAIL soft_align_tick got=%b exp=1", tick[0]); end
        soft_reset = 1'b1;
        advance();
        soft_reset = 1'b0;
        total++;
        if (obs() !== expv()) begin bad++; $display("FAIL soft_reset cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        repeat (39) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL soft_reset cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            if (!sys_reset && fall < 0) fall = cyc;
            if (cyc < 53) n_en += int'(cpu_en);
        end
        total++;
        if (fall != 53) begin bad++; $display("FAIL soft_sys_reset_fall got=%0d exp=53", fall); end
        total++;
        if (n_en != 0) begin bad++; $display("FAIL soft_cpu_en got=%0d exp=0", n_en); end
    endtask

`ifdef CLKGEN_STEP_EN
    task automatic test_step();
        int n_en, g;
        set_div(4, 5);
        halt = 1'b0;
        apply_reset();
        repeat (40) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL step cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
        halt = 1'b1;
        n_en = 0;
        repeat (20) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL step cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            n_en += int'(cpu_en);
        end
        total++;
        if (n_en != 0) begin bad++; $display("FAIL halt_no_en got=%0d exp=0", n_en); end
        n_en = 0;
        repeat (2) begin
            g = 0;
            while (!tick[0] && g < 20) begin
                advance();
                g++;
                total++;
                if (obs() !== expv()) begin bad++; $display("FAIL step cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
                n_en += int'(cpu_en);
            end
            total++;
            if (tick[0] !== 1'b1) begin bad++; $display("FAIL step_wait_tick got=%b exp=1", tick[0]); end
            step = 1'b1;
            repeat (2) begin
                advance();
                total++;
                if (obs() !== expv()) begin bad++; $display("FAIL step cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
                n_en += int'(cpu_en);
            end
            step = 1'b0;
            repeat (6) begin
                advance();
                total++;
                if (obs() !== expv()) begin bad++; $display("FAIL step cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
                n_en += int'(cpu_en);
            end
        end
        total++;
        if (n_en != 2) begin bad++; $display("FAIL step_count got=%0d exp=2", n_en); end
        halt = 1'b0;
        n_en = 0;
        repeat (16) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL step cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            n_en += int'(cpu_en);
        end
        total++;
        if (n_en != 4) begin bad++; $display("FAIL unhalt_count got=%0d exp=4", n_en); end
        halt = 1'b1;
        g = 0;
        advance();
        while (!tick[0] && g < 20) begin
            advance();
            g++;
        end
        step = 1'b1;
        advance();
        step = 1'b0;
        total++;
        if (state !== 2'd3) begin bad++; $display("FAIL step_state got=%0d exp=3", state); end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (obs() !== RST_VEC) begin bad++; $display("FAIL step_async_reset got=%b exp=%b", obs(), RST_VEC); end
        halt = 1'b0;
        apply_reset();
        repeat (10) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL step_restart cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
    endtask
`else
    task automatic test_halt_ignored();
        int n_en, n_bad_state;
        n_en = 0; n_bad_state = 0;
        set_div(4, 5);
        apply_reset();
        repeat (40) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL halt_ignored cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
        halt = 1'b1;
        repeat (16) begin
            step = (cyc % 3) == 0;
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL halt_ignored cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            n_en += int'(cpu_en);
            if (state !== 2'd1) n_bad_state++;
        end
        halt = 1'b0;
        step = 1'b0;
        total++;
        if (n_en != 4) begin bad++; $display("FAIL halt_ignored_count got=%0d exp=4", n_en); end
        total++;
        if (n_bad_state != 0) begin bad++; $display("FAIL halt_ignored_state got=%0d exp=0", n_bad_state); end
    endtask
`endif

    task automatic test_async_reset();
        set_div(6, 3);
        apply_reset();
        repeat (50) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL async_reset cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (obs() !== RST_VEC) begin bad++; $display("FAIL async_reset_values got=%b exp=%b", obs(), RST_VEC); end
        apply_reset();
        repeat (8) begin
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL async_restart cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
    endtask

    task automatic test_random();
        set_div($urandom_range(12), $urandom_range(12));
        apply_reset();
        repeat (3000) begin
            if ($urandom_range(9) == 0) set_div($urandom_range(12), $urandom_range(12));
            soft_reset = $urandom_range(199) == 0;
            step = $urandom_range(9) == 0;
            if ($urandom_range(29) == 0) halt = ~halt;
            advance();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
        soft_reset = 1'b0;
        step = 1'b0;
        halt = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_divider();
        test_small_div();
        test_mid_change();
        test_reset_seq();
        test_soft_reset();
`ifdef CLKGEN_STEP_EN
        test_step();
`else
        test_halt_ignored();
`endif
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
